// File: rtl/interrupt_sequencer.sv
// Interrupt entry sequencer: samples requests at Q1, waits for the current instruction
// to retire, then runs one dummy (NOP) cycle that pushes the PC and vectors to 0x0004.
// Optional build macro IRQ_EXT_EDGE_EN: external INT (irq_src[0]) becomes a rising-edge
// sticky latch cleared by int0_clr; otherwise it is a plain level input.
module interrupt_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  q_count,
  input  logic        instr_done,
  input  logic [3:0]  irq_src,
  input  logic [3:0]  irq_en,
  input  logic        int0_clr,
  input  logic        gie_wr_en,
  input  logic        gie_wr_data,
  input  logic        retfie,
  output logic        gie,
  output logic        force_nop,
  output logic        instr_flush,
  output logic        stack_push,
  output logic        pc_vec_en,
  output logic [12:0] pc_vector,
  output logic        int_active,
  output logic [1:0]  state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  logic [1:0] state;
  logic [1:0] state_nxt;
  logic [3:0] eff_src;
  logic       int_req;
  logic       hw_clr;

`ifdef IRQ_EXT_EDGE_EN
  logic irq0_q;
  logic int0_latch;

  // A new rising edge takes priority over a software clear in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq0_q     <= 1'b0;
      int0_latch <= 1'b0;
    end else begin
      irq0_q <= irq_src[0];
      if (irq_src[0] && !irq0_q)
        int0_latch <= 1'b1;
      else if (int0_clr)
        int0_latch <= 1'b0;
    end
  end

  assign eff_src = {irq_src[3:1], int0_latch};
`else
  logic int0_clr_unused;

  assign int0_clr_unused = int0_clr;
  assign eff_src         = irq_src;
`endif

  assign int_req = gie & (|(eff_src & irq_en));

  // Entry commit: the request survived the Q3 recheck and the instruction retired.
  assign hw_clr = (state == ST_ARMED) && (q_count == 2'd3) && int_req && instr_done;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (q_count == 2'd1 && int_req)
          state_nxt = ST_ARMED;
      end
      ST_ARMED: begin
        if (q_count == 2'd3) begin
          if (!int_req)
            state_nxt = ST_IDLE;
          else if (instr_done)
            state_nxt = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (q_count == 2'd3)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // Hardware clear beats a same-cycle software write or RETFIE.
  always_ff @(posedge clk) begin
    if (rst)
      gie <= 1'b0;
    else if (hw_clr)
      gie <= 1'b0;
    else if (gie_wr_en)
      gie <= gie_wr_data;
    else if (retfie && q_count == 2'd3)
      gie <= 1'b1;
  end

  assign force_nop   = (state == ST_FLUSH);
  assign instr_flush = (state == ST_FLUSH) && (q_count == 2'd3);
  assign stack_push  = (state == ST_FLUSH) && (q_count == 2'd3);
  assign pc_vec_en   = (state == ST_FLUSH) && (q_count == 2'd3);
  assign pc_vector   = 13'h0004;
  assign int_active  = (state != ST_IDLE);
  assign state_dbg   = state;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// Bench for interrupt_sequencer: instruction-cycle-level reference model, directed
// scenarios and a randomized run, all compared phase by phase.
module tb_interrupt_sequencer;

  typedef struct packed {
    logic [3:0] src;
    logic [3:0] en;
    logic       done;
    logic       wr_en;
    logic       wr_data;
    logic       ret;
    logic       clr;
  } stim_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  q_count = 2'd0;
  logic        instr_done = 1'b0;
  logic [3:0]  irq_src = 4'h0;
  logic [3:0]  irq_en = 4'h0;
  logic        int0_clr = 1'b0;
  logic        gie_wr_en = 1'b0;
  logic        gie_wr_data = 1'b0;
  logic        retfie = 1'b0;
  logic        gie, force_nop, instr_flush, stack_push, pc_vec_en, int_active;
  logic [12:0] pc_vector;
  logic [1:0]  state_dbg;

  int checks = 0;
  int errors = 0;

  // Per-phase output vector: {gie, int_active, force_nop, instr_flush, stack_push, pc_vec_en}
  logic [5:0] obs_v[4];
  logic [5:0] exp_v[4];

  // Reference model, one step per instruction cycle.
  logic m_gie, m_armed, m_flush, m_prev0, m_latch;

  interrupt_sequencer dut (
    .clk(clk), .rst(rst), .q_count(q_count), .instr_done(instr_done),
    .irq_src(irq_src), .irq_en(irq_en), .int0_clr(int0_clr),
    .gie_wr_en(gie_wr_en), .gie_wr_data(gie_wr_data), .retfie(retfie),
    .gie(gie), .force_nop(force_nop), .instr_flush(instr_flush),
    .stack_push(stack_push), .pc_vec_en(pc_vec_en), .pc_vector(pc_vector),
    .int_active(int_active), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_gie = 1'b0; m_armed = 1'b0; m_flush = 1'b0; m_prev0 = 1'b0; m_latch = 1'b0;
  endtask

  // Inputs are held for a whole instruction cycle; gie writes and int0_clr land at Q0, RETFIE at Q3.
  task automatic model_cycle(input stim_t s);
    logic       g0, req, armed_after_q1;
    logic [3:0] eff;
    g0 = m_gie;
    if (s.wr_en) m_gie = s.wr_data;
`ifdef IRQ_EXT_EDGE_EN
    if (s.src[0] && !m_prev0) m_latch = 1'b1;
    else if (s.clr) m_latch = 1'b0;
    m_prev0 = s.src[0];
    eff = {s.src[3:1], m_latch};
`else
    eff = s.src;
`endif
    req = m_gie && ((eff & s.en) != 4'h0);
    if (m_flush) begin
      for (int p = 0; p < 4; p++)
        exp_v[p] = {(p == 0) ? g0 : m_gie, 1'b1, 1'b1, {3{p == 3}}};
      if (s.ret) m_gie = 1'b1;
      m_flush = 1'b0;
    end else begin
      armed_after_q1 = m_armed || req;
      for (int p = 0; p < 4; p++)
        exp_v[p] = {(p == 0) ? g0 : m_gie, (p < 2) ? m_armed : armed_after_q1, 4'b0000};
      if (armed_after_q1 && req && s.done) begin
        m_gie = 1'b0; m_flush = 1'b1; m_armed = 1'b0;
      end else begin
        m_armed = armed_after_q1 && req;
        if (s.ret) m_gie = 1'b1;
      end
    end
  endtask

  task automatic drive_cycle(input stim_t s);
    for (int p = 0; p < 4; p++) begin
      @(negedge clk);
      q_count     = 2'(p);
      irq_src     = s.src;
      irq_en      = s.en;
      instr_done  = s.done;
      gie_wr_en   = (p == 0) && s.wr_en;
      gie_wr_data = s.wr_data;
      int0_clr    = (p == 0) && s.clr;
      retfie      = (p == 3) && s.ret;
      #1;
      obs_v[p] = {gie, int_active, force_nop, instr_flush, stack_push, pc_vec_en};
    end
  endtask

  task automatic cyc(input stim_t s);
    model_cycle(s);
    drive_cycle(s);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({gie, int_active, force_nop, instr_flush, stack_push, pc_vec_en} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b expected 000000",
               {gie, int_active, force_nop, instr_flush, stack_push, pc_vec_en});
    end
    checks++;
    if (pc_vector !== 13'h0004) begin
      errors++;
      $display("FAIL reset_pc_vector got %h expected 0004", pc_vector);
    end
  endtask

  // gie set, request with retiring instruction, dummy cycle, back to idle.
  task automatic test_basic_entry();
    stim_t tbl[4];
    tbl[0] = '{4'h0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 4; c++) begin
      cyc(tbl[c]);
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs_v[p] !== exp_v[p]) begin
          errors++;
          $display("FAIL basic_entry cycle %0d q%0d got %b expected %b", c, p, obs_v[p], exp_v[p]);
        end
      end
      if (c == 2) begin
        checks++;
        if (obs_v[0] !== 6'b011000 || obs_v[3] !== 6'b011111) begin
          errors++;
          $display("FAIL basic_dummy_cycle q0 %b q3 %b expected 011000 011111", obs_v[0], obs_v[3]);
        end
      end
    end
  endtask

  // Two-cycle instruction: request waits in ARMED until the instruction retires.
  task automatic test_delayed_retire();
    stim_t tbl[5];
    tbl[0] = '{4'h0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{4'h2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 5; c++) begin
      cyc(tbl[c]);
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs_v[p] !== exp_v[p]) begin
          errors++;
          $display("FAIL delayed_retire cycle %0d q%0d got %b expected %b", c, p, obs_v[p], exp_v[p]);
        end
      end
      checks++;
      if (obs_v[3][1] !== (c == 3)) begin
        errors++;
        $display("FAIL delayed_push_timing cycle %0d got %b expected %b", c, obs_v[3][1], (c == 3));
      end
    end
  endtask

  // All sources requesting with gie=0: nothing happens until RETFIE enables gie.
  task automatic test_gie_off_then_retfie();
    stim_t tbl[5];
    tbl[0] = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[1] = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[4] = '{4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 5; c++) begin
      cyc(tbl[c]);
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs_v[p] !== exp_v[p]) begin
          errors++;
          $display("FAIL gie_off cycle %0d q%0d got %b expected %b", c, p, obs_v[p], exp_v[p]);
        end
      end
      if (c == 3) begin
        checks++;
        if (obs_v[1][4] !== 1'b0 || obs_v[2][4] !== 1'b1) begin
          errors++;
          $display("FAIL retfie_sample int_active q1 %b q2 %b expected 0 1", obs_v[1][4], obs_v[2][4]);
        end
      end
    end
  endtask

  // Request withdrawn while ARMED: back to idle, no pulses, gie unchanged.
  task automatic test_withdraw();
    stim_t tbl[4];
    tbl[0] = '{4'h0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{4'h2, 4'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3] = '{4'h0, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int c = 0; c < 4; c++) begin
      cyc(tbl[c]);
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs_v[p] !== exp_v[p]) begin
          errors++;
          $display("FAIL withdraw cycle %0d q%0d got %b expected %b", c, p, obs_v[p], exp_v[p]);
        end
      end
    end
    checks++;
    if (obs_v[0] !== 6'b100000) begin
      errors++;
      $display("FAIL withdraw_final got %b expected 100000", obs_v[0]);
    end
    // Drop gie for the following tests.
    cyc('{4'h0, 4'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
  endtask

  // External INT held high through the ISR: level retriggers, edge mode fires once.
  task automatic test_ext_int_hold();
    stim_t tbl[8];
    int    pushes;
    int    exp_pushes;
    tbl[0] = '{4'h1, 4'h1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[3] = '{4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[5] = '{4'h1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[6] = '{4'h0, 4'h1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[7] = '{4'h0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    pushes = 0;
`ifdef IRQ_EXT_EDGE_EN
    exp_pushes = 1;
`else
    exp_pushes = 2;
`endif
    for (int c = 0; c < 8; c++) begin
      cyc(tbl[c]);
      for (int p = 0; p < 4; p++) begin
        if (obs_v[p][1] === 1'b1) pushes++;
        checks++;
        if (obs_v[p] !== exp_v[p]) begin
          errors++;
          $display("FAIL ext_int_hold cycle %0d q%0d got %b expected %b", c, p, obs_v[p], exp_v[p]);
        end
      end
    end
    checks++;
    if (pushes !== exp_pushes) begin
      errors++;
      $display("FAIL ext_int_sequences got %0d expected %0d", pushes, exp_pushes);
    end
  endtask

  // Reset at Q1 of the dummy cycle aborts the sequence with no push.
  task automatic test_reset_mid_flush();
    stim_t s_on;
    stim_t s_req;
    s_on  = '{4'h0, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    s_req = '{4'h2, 4'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    cyc(s_on);
    cyc(s_req);
    @(negedge clk);
    q_count = 2'd0; retfie = 1'b0; gie_wr_en = 1'b0; int0_clr = 1'b0;
    #1;
    checks++;
    if (force_nop !== 1'b1) begin
      errors++;
      $display("FAIL rst_flush_entry force_nop got %b expected 1", force_nop);
    end
    @(negedge clk);
    q_count = 2'd1; rst = 1'b1;
    @(negedge clk);
    q_count = 2'd2; rst = 1'b0;
    #1;
    checks++;
    if ({gie, int_active, force_nop, instr_flush, stack_push, pc_vec_en} !== 6'b0) begin
      errors++;
      $display("FAIL rst_flush_outputs got %b expected 000000",
               {gie, int_active, force_nop, instr_flush, stack_push, pc_vec_en});
    end
    @(negedge clk);
    q_count = 2'd3;
    #1;
    checks++;
    if ({stack_push, pc_vec_en, instr_flush} !== 3'b000) begin
      errors++;
      $display("FAIL rst_flush_no_push got %b expected 000", {stack_push, pc_vec_en, instr_flush});
    end
    model_reset();
  endtask

  task automatic test_random();
    stim_t s;
    for (int c = 0; c < 300; c++) begin
      s.src     = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom_range(0, 15));
      s.en      = 4'($urandom_range(0, 15));
      s.done    = ($urandom_range(0, 3) != 0);
      s.wr_en   = ($urandom_range(0, 4) == 0);
      s.wr_data = ($urandom_range(0, 2) != 0);
      s.ret     = ($urandom_range(0, 5) == 0);
      s.clr     = ($urandom_range(0, 3) == 0);
      cyc(s);
      for (int p = 0; p < 4; p++) begin
        checks++;
        if (obs_v[p] !== exp_v[p]) begin
          errors++;
          $display("FAIL random cycle %0d q%0d got %b expected %b", c, p, obs_v[p], exp_v[p]);
        end
      end
      checks++;
      if (pc_vector !== 13'h0004) begin
        errors++;
        $display("FAIL random_pc_vector cycle %0d got %h expected 0004", c, pc_vector);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic_entry();
    test_delayed_retire();
    test_gie_off_then_retfie();
    test_withdraw();
    test_ext_int_hold();
    test_reset_mid_flush();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_sequencer.md
INTERRUPT_SEQUENCER -- requirements
Module: interrupt_sequencer

Interface
REQ-001 SHALL have: clk  input  1  clock; all state updates on rising edge.
REQ-002 SHALL have: rst  input  1  reset; synchronous, active-high.
REQ-003 SHALL have: q_count  input  2  Q-phase of current instruction cycle (0..3), from instruction decoder.
REQ-004 SHALL have: instr_done  input  1  current instruction retires at this q_count==3 (0 during first cycle of two-cycle instructions).
REQ-005 SHALL have: irq_src  input  4  interrupt flags; bit 0 = external INT pin.
REQ-006 SHALL have: irq_en  input  4  per-source enables.
REQ-007 SHALL have: int0_clr  input  1  software clear of the latched INT flag.
REQ-008 SHALL have: gie_wr_en, gie_wr_data  input  1,1  software write of global interrupt enable.
REQ-009 SHALL have: retfie  input  1  RETFIE retiring (valid at q_count==3).
REQ-010 SHALL have: gie  output  1  global interrupt enable.
REQ-011 SHALL have: force_nop  output  1  decoder suppresses all outputs of current instruction.
REQ-012 SHALL have: instr_flush, stack_push, pc_vec_en  output  1 each  flush fetch register, push return PC, load PC from pc_vector.
REQ-013 SHALL have: pc_vector  output  13  constant 13'h0004.
REQ-014 SHALL have: int_active  output  1  high whenever state != IDLE.

Function
REQ-015 int_req SHALL be gie AND OR(eff_src & irq_en).
REQ-016 int_req SHALL be sampled only when q_count==1; a sampled 1 in IDLE SHALL move state to ARMED on that edge.
REQ-017 ARMED at q_count==3: int_req==0 -> IDLE (request withdrawn); int_req==1 and instr_done==0 -> stay ARMED; int_req==1 and instr_done==1 -> gie<=0, state FLUSH.
REQ-018 FLUSH SHALL last exactly one full instruction cycle (q 0..3) with force_nop=1 throughout.
REQ-019 FLUSH at q_count==3 SHALL pulse stack_push, pc_vec_en, instr_flush for one clk, then state IDLE.
REQ-020 Outside FLUSH, force_nop, stack_push, pc_vec_en, instr_flush SHALL be 0.
REQ-021 Latency: request sampled in cycle n (instr_done=1) -> cycle n+1 dummy -> vector loaded at end of n+1.
REQ-022 retfie at q_count==3 SHALL set gie<=1; a request pending then SHALL be sampled next q_count==1.
REQ-023 gie_wr_en SHALL load gie<=gie_wr_data; hardware clear (REQ-017) SHALL win over a simultaneous write or retfie.
REQ-024 gie changes made in ARMED before q_count==3 SHALL be honoured by the REQ-017 recheck.
REQ-025 A new request during FLUSH SHALL be ignored (gie=0); no nesting.

Reset
REQ-026 rst SHALL force: state IDLE, gie=0, INT latch=0, edge-detect history=0, all pulse outputs 0, int_active=0.
REQ-027 rst mid-FLUSH SHALL abort the sequence with no stack_push or pc_vec_en issued.

Configuration
REQ-028 Macro IRQ_EXT_EDGE_EN defined: irq_src[0] registered; its rising edge sets a sticky INT latch cleared by int0_clr (set wins on same cycle); eff_src[0] = latch.
REQ-029 IRQ_EXT_EDGE_EN undefined: eff_src[0] = irq_src[0] (level); int0_clr ignored; no edge registers. eff_src[3:1] = irq_src[3:1] in both builds.

Verification
REQ-030 gie=1, irq_en=4'b0010, irq_src[1] rises before q1 of cycle n, instr_done=1 -> gie=0 at q3 of n; force_nop=1 all of n+1; stack_push/pc_vec_en/instr_flush one clk at q3 of n+1; pc_vector=0x0004.
REQ-031 As REQ-030 but instr_done=0 in cycle n, 1 in n+1 -> FLUSH in n+2, vector at q3 of n+2.
REQ-032 gie=0, irq_src=4'hF, irq_en=4'hF -> no int_active ever; then retfie -> sequence begins next cycle's q1 sample.
REQ-033 ARMED, irq_src cleared before q3 -> back to IDLE, no pulses, gie stays 1.
REQ-034 With IRQ_EXT_EDGE_EN: irq_src[0] 0->1 held high, ISR does int0_clr -> exactly one sequence; without macro: held level retriggers after retfie.
REQ-035 rst asserted at q1 of FLUSH -> all outputs 0 next clk, gie=0, no stack_push.
